axi4_lite_monitor: RTL and testbench
====================================

AXI4_LITE_MONITOR -- requirements
Module: axi4_lite_monitor

Interface
REQ-001 SHALL have parameter ID_W, default 12, AXI ID width.
REQ-002 SHALL have parameter ADDR_W, default 32, address width.
REQ-003 SHALL have parameter DATA_W, default 32, data width; WSTRB width is DATA_W/8.
REQ-004 SHALL have parameter TRACK_DEPTH, default 4, per-direction outstanding-tracking FIFO depth (power of 2).
REQ-005 SHALL have parameter TRACE_DEPTH, default 16, per-direction trace FIFO depth (power of 2).
REQ-006 SHALL have parameter TS_W, default 16, timestamp and latency width.
REQ-007 SHALL have aclk  in  1  sole clock; all logic is rising-edge.
REQ-008 SHALL have aresetn  in  1  asynchronous active-low reset.
REQ-009 SHALL have s_axi_*  in/out  per channel  manager-facing AW(id,addr), W(data,strb,last), B(id), AR(id,len,addr), R(id,data,last) with valid/ready.
REQ-010 SHALL have m_axi_*  out/in  per channel  subordinate-facing mirror of s_axi_*.
REQ-011 SHALL have enable  in  1  when low, no tracking, counting or trace pushes occur.
REQ-012 SHALL have clear  in  1  synchronous pulse that zeroes all counters and the err flag.
REQ-013 SHALL have tw_valid/tw_ready  out/in  1  write-trace stream handshake; tw_id ID_W, tw_addr ADDR_W, tw_lat TS_W.
REQ-014 SHALL have tr_valid/tr_ready  out/in  1  read-trace stream; tr_id, tr_addr, tr_lat, plus tr_data DATA_W (last beat).
REQ-015 SHALL have wr_count, rd_count  out  32  completed write/read transactions.
REQ-016 SHALL have untracked_count, trace_drop_count  out  32  transactions lacking a tracker slot or trace FIFO space.
REQ-017 SHALL have err  out  1  sticky flag for a response with nothing outstanding.

Function
REQ-018 SHALL pass all s_axi_*/m_axi_* signals combinationally with zero latency, independent of enable, reset and FIFO state.
REQ-019 SHALL run a free-running TS_W-bit timestamp that wraps modulo 2^TS_W.
REQ-020 SHALL, on AW handshake (valid&&ready), push {id, addr, timestamp} into the write tracker; if the tracker is full, it SHALL instead increment the pending-untracked counter and untracked_count.
REQ-021 SHALL, on B handshake, pop the write tracker if non-empty, else decrement the pending-untracked counter if non-zero, else set err.
REQ-022 SHALL, on a tracker pop, compute latency = timestamp - stored timestamp (mod 2^TS_W) and push the record into the write trace FIFO, or increment trace_drop_count if that FIFO is full.
REQ-023 SHALL apply REQ-020..022 to reads: AR handshake pushes; completion is an R handshake with rlast=1; tr_data captures rdata of that beat.
REQ-024 SHALL increment wr_count on every B handshake and rd_count on every rlast R handshake, including untracked ones.
REQ-025 SHALL, when a push and a pop hit the same tracker in one cycle, perform both; if full, the pop frees the slot for the push.
REQ-026 SHALL treat write and read paths independently; simultaneous completions both record in the same cycle.
REQ-027 SHALL, for a request and its response in one cycle with an empty tracker, resolve the response first (err set), then push the request.
REQ-028 SHALL saturate all 32-bit counters at all-ones.
REQ-029 SHALL, on clear coincident with a counting event, leave the counter at 0.
REQ-030 SHALL present trace FIFO head combinationally on tw_*/tr_*; an entry pops on valid&&ready; first-word latency is 1 cycle after completion.

Reset
REQ-031 SHALL, on aresetn low, empty all FIFOs, zero timestamp, counters, pending-untracked counters and err, and drive tw_valid=tr_valid=0.
REQ-032 SHALL, after reset mid-transaction, treat subsequent responses with no tracker entry per REQ-021 (err set).

Structure
REQ-033 SHALL keep shared constants (record field widths, counter width 32) in package axi4_lite_monitor_pkg.
REQ-034 SHALL instantiate one generic sub-module, sync_fifo (params WIDTH, DEPTH; full/empty; simultaneous push/pop), four times: two trackers, two trace FIFOs.

Verification
REQ-035 SHALL verify: single write addr 0x40, B 5 cycles after AW -> one tw record addr 0x40, lat 5; wr_count=1.
REQ-036 SHALL verify: 6 back-to-back ARs, TRACK_DEPTH=4, in-order rlast responses -> 4 tr records, untracked_count=2, rd_count=6, err=0.
REQ-037 SHALL verify: tw_ready held low across 18 writes, TRACE_DEPTH=16 -> 16 records retained, trace_drop_count=2.
REQ-038 SHALL verify: B handshake with nothing outstanding -> err=1 until clear pulse, then err=0, counters 0.
REQ-039 SHALL verify: B and rlast R in the same cycle -> tw_valid and tr_valid both asserted next cycle.
REQ-040 SHALL verify: aresetn asserted while 2 ARs outstanding -> trackers empty; subsequent R rlast sets err, rd_count=1.

Source files
------------

// File: rtl/axi4_lite_monitor_pkg.sv
// Shared widths and helpers for the AXI4-Lite transaction monitor.
// Counters are fixed at 32 bits and saturate at all-ones.
package axi4_lite_monitor_pkg;

  localparam int CNT_W = 32;
  localparam int LEN_W = 8;

  typedef logic [CNT_W-1:0] cnt_t;

  function automatic int trk_w(int id_w, int addr_w, int ts_w);
    return id_w + addr_w + ts_w;
  endfunction

  function automatic cnt_t sat_add(cnt_t a, logic [1:0] n);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-1){1'b0}}, n};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO; a pop frees the slot for a same-cycle push.
// Head is presented combinationally on dout.
module sync_fifo
  import axi4_lite_monitor_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign dout  = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    wptr_d  = wptr_q + (AW+1)'(do_push);
    rptr_d  = rptr_q + (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/axi4_lite_monitor.sv
// Passive AXI4-Lite monitor: zero-latency pass-through plus latency
// tracing, completion counters and an orphan-response error flag.
module axi4_lite_monitor
  import axi4_lite_monitor_pkg::*;
#(
  parameter int ID_W        = 12,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TRACK_DEPTH = 4,
  parameter int TRACE_DEPTH = 16,
  parameter int TS_W        = 16
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [ID_W-1:0]     s_axi_awid,
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic                s_axi_wlast,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [ID_W-1:0]     s_axi_bid,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic [ID_W-1:0]     s_axi_arid,
  input  logic [LEN_W-1:0]    s_axi_arlen,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [ID_W-1:0]     s_axi_rid,
  output logic [DATA_W-1:0]   s_axi_rdata,
  output logic                s_axi_rlast,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready,
  output logic [ID_W-1:0]     m_axi_awid,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [ID_W-1:0]     m_axi_bid,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic [ID_W-1:0]     m_axi_arid,
  output logic [LEN_W-1:0]    m_axi_arlen,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [ID_W-1:0]     m_axi_rid,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic                m_axi_rlast,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready,
  input  logic                enable,
  input  logic                clear,
  output logic                tw_valid,
  input  logic                tw_ready,
  output logic [ID_W-1:0]     tw_id,
  output logic [ADDR_W-1:0]   tw_addr,
  output logic [TS_W-1:0]     tw_lat,
  output logic                tr_valid,
  input  logic                tr_ready,
  output logic [ID_W-1:0]     tr_id,
  output logic [ADDR_W-1:0]   tr_addr,
  output logic [TS_W-1:0]     tr_lat,
  output logic [DATA_W-1:0]   tr_data,
  output logic [CNT_W-1:0]    wr_count,
  output logic [CNT_W-1:0]    rd_count,
  output logic [CNT_W-1:0]    untracked_count,
  output logic [CNT_W-1:0]    trace_drop_count,
  output logic                err
);

  localparam int TRK_W = trk_w(ID_W, ADDR_W, TS_W);
  localparam int RTR_W = TRK_W + DATA_W;

  assign m_axi_awid    = s_axi_awid;
  assign m_axi_awaddr  = s_axi_awaddr;
  assign m_axi_awvalid = s_axi_awvalid;
  assign s_axi_awready = m_axi_awready;
  assign m_axi_wdata   = s_axi_wdata;
  assign m_axi_wstrb   = s_axi_wstrb;
  assign m_axi_wlast   = s_axi_wlast;
  assign m_axi_wvalid  = s_axi_wvalid;
  assign s_axi_wready  = m_axi_wready;
  assign s_axi_bid     = m_axi_bid;
  assign s_axi_bvalid  = m_axi_bvalid;
  assign m_axi_bready  = s_axi_bready;
  assign m_axi_arid    = s_axi_arid;
  assign m_axi_arlen   = s_axi_arlen;
  assign m_axi_araddr  = s_axi_araddr;
  assign m_axi_arvalid = s_axi_arvalid;
  assign s_axi_arready = m_axi_arready;
  assign s_axi_rid     = m_axi_rid;
  assign s_axi_rdata   = m_axi_rdata;
  assign s_axi_rlast   = m_axi_rlast;
  assign s_axi_rvalid  = m_axi_rvalid;
  assign m_axi_rready  = s_axi_rready;

  logic [TS_W-1:0] ts_q, ts_d;
  cnt_t wr_cnt_q, wr_cnt_d;
  cnt_t rd_cnt_q, rd_cnt_d;
  cnt_t unt_q, unt_d;
  cnt_t drop_q, drop_d;
  cnt_t wpend_q, wpend_d;
  cnt_t rpend_q, rpend_d;
  logic err_q, err_d;

  logic w_req, w_rsp, r_req, r_rsp;
  logic wtrk_push, wtrk_pop, wtrk_full, wtrk_empty;
  logic rtrk_push, rtrk_pop, rtrk_full, rtrk_empty;
  logic wtr_push, wtr_pop, wtr_full, wtr_empty;
  logic rtr_push, rtr_pop, rtr_full, rtr_empty;
  logic w_unt, r_unt, w_dec, r_dec;
  logic w_err, r_err, w_drop, r_drop;
  logic [TRK_W-1:0] wtrk_din, wtrk_dout;
  logic [TRK_W-1:0] rtrk_din, rtrk_dout;
  logic [TRK_W-1:0] wtr_din, wtr_dout;
  logic [RTR_W-1:0] rtr_din, rtr_dout;
  logic [ID_W-1:0]   wt_id, rt_id;
  logic [ADDR_W-1:0] wt_addr, rt_addr;
  logic [TS_W-1:0]   wt_ts, rt_ts;

  assign {wt_id, wt_addr, wt_ts} = wtrk_dout;
  assign {rt_id, rt_addr, rt_ts} = rtrk_dout;
  assign wtrk_din = {s_axi_awid, s_axi_awaddr, ts_q};
  assign rtrk_din = {s_axi_arid, s_axi_araddr, ts_q};
  assign wtr_din  = {wt_id, wt_addr, TS_W'(ts_q - wt_ts)};
  assign rtr_din  = {rt_id, rt_addr, TS_W'(ts_q - rt_ts), m_axi_rdata};

  assign tw_valid = ~wtr_empty;
  assign tr_valid = ~rtr_empty;
  assign {tw_id, tw_addr, tw_lat} = wtr_dout;
  assign {tr_id, tr_addr, tr_lat, tr_data} = rtr_dout;

  // Responses resolve before requests: a pop first, then the push.
  always_comb begin
    w_req    = enable & s_axi_awvalid & m_axi_awready;
    w_rsp    = enable & m_axi_bvalid & s_axi_bready;
    r_req    = enable & s_axi_arvalid & m_axi_arready;
    r_rsp    = enable & m_axi_rvalid & s_axi_rready & m_axi_rlast;
    wtrk_pop  = w_rsp & ~wtrk_empty;
    rtrk_pop  = r_rsp & ~rtrk_empty;
    wtrk_push = w_req & (~wtrk_full | wtrk_pop);
    rtrk_push = r_req & (~rtrk_full | rtrk_pop);
    w_unt    = w_req & ~wtrk_push;
    r_unt    = r_req & ~rtrk_push;
    w_dec    = w_rsp & wtrk_empty & (wpend_q != '0);
    r_dec    = r_rsp & rtrk_empty & (rpend_q != '0);
    w_err    = w_rsp & wtrk_empty & (wpend_q == '0);
    r_err    = r_rsp & rtrk_empty & (rpend_q == '0);
    wtr_pop  = tw_valid & tw_ready;
    rtr_pop  = tr_valid & tr_ready;
    wtr_push = wtrk_pop & (~wtr_full | wtr_pop);
    rtr_push = rtrk_pop & (~rtr_full | rtr_pop);
    w_drop   = wtrk_pop & ~wtr_push;
    r_drop   = rtrk_pop & ~rtr_push;
  end

  always_comb begin
    ts_d    = ts_q + TS_W'(1);
    wpend_d = w_dec ? wpend_q - cnt_t'(1)
                    : sat_add(wpend_q, 2'(w_unt));
    rpend_d = r_dec ? rpend_q - cnt_t'(1)
                    : sat_add(rpend_q, 2'(r_unt));
    wr_cnt_d = sat_add(wr_cnt_q, 2'(w_rsp));
    rd_cnt_d = sat_add(rd_cnt_q, 2'(r_rsp));
    unt_d    = sat_add(unt_q, 2'(w_unt) + 2'(r_unt));
    drop_d   = sat_add(drop_q, 2'(w_drop) + 2'(r_drop));
    err_d    = err_q | w_err | r_err;
    if (clear) begin
      wr_cnt_d = '0;
      rd_cnt_d = '0;
      unt_d    = '0;
      drop_d   = '0;
      err_d    = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ts_q     <= '0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      unt_q    <= '0;
      drop_q   <= '0;
      wpend_q  <= '0;
      rpend_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      ts_q     <= ts_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      unt_q    <= unt_d;
      drop_q   <= drop_d;
      wpend_q  <= wpend_d;
      rpend_q  <= rpend_d;
      err_q    <= err_d;
    end
  end

  assign wr_count         = wr_cnt_q;
  assign rd_count         = rd_cnt_q;
  assign untracked_count  = unt_q;
  assign trace_drop_count = drop_q;
  assign err              = err_q;

  sync_fifo #(.WIDTH(TRK_W), .DEPTH(TRACK_DEPTH)) u_wtrk (
    .clk(aclk), .rst_n(aresetn),
    .push(wtrk_push), .din(wtrk_din), .pop(wtrk_pop),
    .dout(wtrk_dout), .full(wtrk_full), .empty(wtrk_empty)
  );

  sync_fifo #(.WIDTH(TRK_W), .DEPTH(TRACK_DEPTH)) u_rtrk (
    .clk(aclk), .rst_n(aresetn),
    .push(rtrk_push), .din(rtrk_din), .pop(rtrk_pop),
    .dout(rtrk_dout), .full(rtrk_full), .empty(rtrk_empty)
  );

  sync_fifo #(.WIDTH(TRK_W), .DEPTH(TRACE_DEPTH)) u_wtr (
    .clk(aclk), .rst_n(aresetn),
    .push(wtr_push), .din(wtr_din), .pop(wtr_pop),
    .dout(wtr_dout), .full(wtr_full), .empty(wtr_empty)
  );

  sync_fifo #(.WIDTH(RTR_W), .DEPTH(TRACE_DEPTH)) u_rtr (
    .clk(aclk), .rst_n(aresetn),
    .push(rtr_push), .din(rtr_din), .pop(rtr_pop),
    .dout(rtr_dout), .full(rtr_full), .empty(rtr_empty)
  );

endmodule

// File: tb/tb_axi4_lite_monitor.sv
// Bench for axi4_lite_monitor: vector table, directed corner cases and
// random traffic checked against a queue-based transaction model.
module tb_axi4_lite_monitor;

  localparam int TRACK = 4;
  localparam int TRACE = 16;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic [11:0] s_axi_awid, m_axi_awid, s_axi_bid, m_axi_bid;
  logic [31:0] s_axi_awaddr, m_axi_awaddr;
  logic s_axi_awvalid, m_axi_awvalid, s_axi_awready, m_axi_awready;
  logic [31:0] s_axi_wdata, m_axi_wdata;
  logic [3:0] s_axi_wstrb, m_axi_wstrb;
  logic s_axi_wlast, m_axi_wlast, s_axi_wvalid, m_axi_wvalid;
  logic s_axi_wready, m_axi_wready;
  logic s_axi_bvalid, m_axi_bvalid, s_axi_bready, m_axi_bready;
  logic [11:0] s_axi_arid, m_axi_arid, s_axi_rid, m_axi_rid;
  logic [7:0] s_axi_arlen, m_axi_arlen;
  logic [31:0] s_axi_araddr, m_axi_araddr;
  logic s_axi_arvalid, m_axi_arvalid, s_axi_arready, m_axi_arready;
  logic [31:0] s_axi_rdata, m_axi_rdata;
  logic s_axi_rlast, m_axi_rlast, s_axi_rvalid, m_axi_rvalid;
  logic s_axi_rready, m_axi_rready;
  logic enable, clear, tw_valid, tw_ready, tr_valid, tr_ready;
  logic [11:0] tw_id, tr_id;
  logic [31:0] tw_addr, tr_addr, tr_data;
  logic [15:0] tw_lat, tr_lat;
  logic [31:0] wr_count, rd_count, untracked_count, trace_drop_count;
  logic err;

  axi4_lite_monitor dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wlast(s_axi_wlast), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_arlen(s_axi_arlen),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_arid(m_axi_arid), .m_axi_arlen(m_axi_arlen),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready),
    .enable(enable), .clear(clear),
    .tw_valid(tw_valid), .tw_ready(tw_ready),
    .tw_id(tw_id), .tw_addr(tw_addr), .tw_lat(tw_lat),
    .tr_valid(tr_valid), .tr_ready(tr_ready),
    .tr_id(tr_id), .tr_addr(tr_addr), .tr_lat(tr_lat),
    .tr_data(tr_data),
    .wr_count(wr_count), .rd_count(rd_count),
    .untracked_count(untracked_count),
    .trace_drop_count(trace_drop_count), .err(err)
  );

  typedef struct packed {
    logic [11:0] id;
    logic [31:0] addr;
    logic [15:0] ts;
  } trk_t;

  typedef struct packed {
    logic [11:0] id;
    logic [31:0] addr;
    logic [15:0] lat;
    logic [31:0] data;
  } trc_t;

  typedef struct {
    bit aw, b, ar, r, rl, clr;
    int unsigned wr, rd, unt;
    bit er;
  } vec_t;

  trk_t wtq[$], rtq[$];
  trc_t twq[$], trq[$];
  int unsigned m_wr, m_rd, m_unt, m_drop, m_wpend, m_rpend;
  bit m_err;
  logic [15:0] mts;
  int errors = 0;
  int checks = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    wtq.delete(); rtq.delete(); twq.delete(); trq.delete();
    m_wr = 0; m_rd = 0; m_unt = 0; m_drop = 0;
    m_wpend = 0; m_rpend = 0; m_err = 0; mts = '0;
  endtask

  // Apply the monitor's rules to the inputs held over the coming edge.
  task automatic model_edge();
    bit awh, bh, arh, rh;
    trk_t t;
    trc_t c;
    awh = s_axi_awvalid && m_axi_awready;
    bh  = m_axi_bvalid && s_axi_bready;
    arh = s_axi_arvalid && m_axi_arready;
    rh  = m_axi_rvalid && s_axi_rready && m_axi_rlast;
    if (tw_ready && twq.size() > 0) twq.delete(0);
    if (tr_ready && trq.size() > 0) trq.delete(0);
    if (enable) begin
      if (bh) begin
        m_wr++;
        if (wtq.size() > 0) begin
          t = wtq.pop_front();
          c = '{t.id, t.addr, 16'(mts - t.ts), 32'h0};
          if (twq.size() < TRACE) twq.push_back(c);
          else m_drop++;
        end else if (m_wpend > 0) m_wpend--;
        else m_err = 1;
      end
      if (awh) begin
        if (wtq.size() < TRACK)
          wtq.push_back('{s_axi_awid, s_axi_awaddr, mts});
        else begin m_unt++; m_wpend++; end
      end
      if (rh) begin
        m_rd++;
        if (rtq.size() > 0) begin
          t = rtq.pop_front();
          c = '{t.id, t.addr, 16'(mts - t.ts), m_axi_rdata};
          if (trq.size() < TRACE) trq.push_back(c);
          else m_drop++;
        end else if (m_rpend > 0) m_rpend--;
        else m_err = 1;
      end
      if (arh) begin
        if (rtq.size() < TRACK)
          rtq.push_back('{s_axi_arid, s_axi_araddr, mts});
        else begin m_unt++; m_rpend++; end
      end
    end
    if (clear) begin
      m_wr = 0; m_rd = 0; m_unt = 0; m_drop = 0; m_err = 0;
    end
    mts++;
  endtask

  task automatic model_cmp();
    chk("wr_count", wr_count, m_wr);
    chk("rd_count", rd_count, m_rd);
    chk("untracked", untracked_count, m_unt);
    chk("drop", trace_drop_count, m_drop);
    chk("err", err, m_err);
    chk("tw_valid", tw_valid, twq.size() != 0);
    chk("tr_valid", tr_valid, trq.size() != 0);
    if (twq.size() > 0 && tw_valid) begin
      chk("tw_id", tw_id, twq[0].id);
      chk("tw_addr", tw_addr, twq[0].addr);
      chk("tw_lat", tw_lat, twq[0].lat);
    end
    if (trq.size() > 0 && tr_valid) begin
      chk("tr_id", tr_id, trq[0].id);
      chk("tr_addr", tr_addr, trq[0].addr);
      chk("tr_lat", tr_lat, trq[0].lat);
      chk("tr_data", tr_data, trq[0].data);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge aclk);
    #1;
    model_cmp();
  endtask

  task automatic idle_inputs();
    s_axi_awvalid = 0; s_axi_wvalid = 0; m_axi_bvalid = 0;
    s_axi_arvalid = 0; m_axi_rvalid = 0; m_axi_rlast = 0;
    m_axi_awready = 1; m_axi_wready = 1; s_axi_bready = 1;
    m_axi_arready = 1; s_axi_rready = 1;
    tw_ready = 1; tr_ready = 1; enable = 1; clear = 0;
  endtask

  task automatic do_reset();
    aresetn = 0;
    idle_inputs();
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1;
    model_reset();
  endtask

  task automatic drain_tw(output int n);
    n = 0;
    tw_ready = 1;
    for (int k = 0; k < 40 && tw_valid; k++) begin
      n++;
      step();
    end
  endtask

  task automatic drain_tr(output int n);
    n = 0;
    tr_ready = 1;
    for (int k = 0; k < 40 && tr_valid; k++) begin
      n++;
      step();
    end
  endtask

  vec_t tbl[17];
  int n;

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    s_axi_awid = '0; s_axi_awaddr = '0; s_axi_wdata = '0;
    s_axi_wstrb = '0; s_axi_wlast = 0; m_axi_bid = '0;
    s_axi_arid = '0; s_axi_arlen = '0; s_axi_araddr = '0;
    m_axi_rid = '0; m_axi_rdata = '0;
    idle_inputs();

    //            aw b ar r rl clr  wr rd unt err
    tbl[0]  = '{0,0,0,0,0,0, 0,0,0,0};
    tbl[1]  = '{0,1,0,0,0,0, 1,0,0,1};
    tbl[2]  = '{1,0,0,0,0,0, 1,0,0,1};
    tbl[3]  = '{0,1,0,0,0,0, 2,0,0,1};
    tbl[4]  = '{0,0,0,0,0,1, 0,0,0,0};
    tbl[5]  = '{0,0,1,1,1,0, 0,1,0,1};
    tbl[6]  = '{0,0,0,1,0,0, 0,1,0,1};
    tbl[7]  = '{0,0,0,1,1,0, 0,2,0,1};
    tbl[8]  = '{1,0,0,0,0,0, 0,2,0,1};
    tbl[9]  = '{0,1,0,0,0,1, 0,0,0,0};
    tbl[10] = '{0,0,0,0,0,0, 0,0,0,0};
    tbl[11] = '{1,0,0,0,0,0, 0,0,0,0};
    tbl[12] = '{1,0,0,0,0,0, 0,0,0,0};
    tbl[13] = '{1,0,0,0,0,0, 0,0,0,0};
    tbl[14] = '{1,0,0,0,0,0, 0,0,0,0};
    tbl[15] = '{1,0,0,0,0,0, 0,0,1,0};
    tbl[16] = '{0,1,0,0,0,0, 1,0,1,0};

    do_reset();
    chk("reset_tw_valid", tw_valid, 1'b0);
    chk("reset_tr_valid", tr_valid, 1'b0);
    for (int i = 0; i < 17; i++) begin
      s_axi_awvalid = tbl[i].aw;
      s_axi_awaddr  = 32'h1000 + 32'(i);
      m_axi_bvalid  = tbl[i].b;
      s_axi_arvalid = tbl[i].ar;
      s_axi_araddr  = 32'h2000 + 32'(i);
      m_axi_rvalid  = tbl[i].r;
      m_axi_rlast   = tbl[i].rl;
      m_axi_rdata   = 32'hD000 + 32'(i);
      clear         = tbl[i].clr;
      step();
      idle_inputs();
      chk("tbl_wr", wr_count, tbl[i].wr);
      chk("tbl_rd", rd_count, tbl[i].rd);
      chk("tbl_unt", untracked_count, tbl[i].unt);
      chk("tbl_err", err, tbl[i].er);
    end

    // Single write, B five cycles after AW.
    do_reset();
    s_axi_awid = 12'h3; s_axi_awaddr = 32'h40; s_axi_awvalid = 1;
    step();
    s_axi_awvalid = 0;
    repeat (4) step();
    m_axi_bvalid = 1;
    step();
    m_axi_bvalid = 0;
    chk("w1_valid", tw_valid, 1'b1);
    chk("w1_addr", tw_addr, 32'h40);
    chk("w1_id", tw_id, 12'h3);
    chk("w1_lat", tw_lat, 16'd5);
    chk("w1_wr", wr_count, 32'd1);

    // Six reads against a four-deep tracker.
    do_reset();
    tr_ready = 0;
    for (int i = 0; i < 6; i++) begin
      s_axi_arid = 12'(i); s_axi_araddr = 32'h100 + 32'(i * 4);
      s_axi_arvalid = 1;
      step();
    end
    s_axi_arvalid = 0;
    for (int i = 0; i < 6; i++) begin
      m_axi_rvalid = 1; m_axi_rlast = 1; m_axi_rdata = 32'hA0 + 32'(i);
      step();
    end
    m_axi_rvalid = 0; m_axi_rlast = 0;
    chk("r6_unt", untracked_count, 32'd2);
    chk("r6_rd", rd_count, 32'd6);
    chk("r6_err", err, 1'b0);
    chk("r6_addr0", tr_addr, 32'h100);
    drain_tr(n);
    chk("r6_records", n, 4);

    // Trace FIFO overflow with the consumer stalled.
    do_reset();
    tw_ready = 0;
    for (int i = 0; i < 18; i++) begin
      s_axi_awaddr = 32'h300 + 32'(i); s_axi_awvalid = 1;
      step();
      s_axi_awvalid = 0; m_axi_bvalid = 1;
      step();
      m_axi_bvalid = 0;
    end
    chk("ov_drop", trace_drop_count, 32'd2);
    chk("ov_wr", wr_count, 32'd18);
    drain_tw(n);
    chk("ov_records", n, 16);

    // Orphan B sets a sticky err that only clear removes.
    do_reset();
    m_axi_bvalid = 1;
    step();
    m_axi_bvalid = 0;
    chk("orph_err", err, 1'b1);
    repeat (3) step();
    chk("orph_sticky", err, 1'b1);
    clear = 1;
    step();
    clear = 0;
    chk("clr_err", err, 1'b0);
    chk("clr_wr", wr_count, 32'd0);

    // Simultaneous write and read completion.
    do_reset();
    tw_ready = 0; tr_ready = 0;
    s_axi_awvalid = 1;
    step();
    s_axi_awvalid = 0; s_axi_arvalid = 1;
    step();
    s_axi_arvalid = 0;
    m_axi_bvalid = 1; m_axi_rvalid = 1; m_axi_rlast = 1;
    step();
    idle_inputs();
    tw_ready = 0; tr_ready = 0;
    chk("both_tw", tw_valid, 1'b1);
    chk("both_tr", tr_valid, 1'b1);

    // Reset with reads outstanding.
    do_reset();
    s_axi_arvalid = 1;
    repeat (2) step();
    s_axi_arvalid = 0;
    do_reset();
    m_axi_rvalid = 1; m_axi_rlast = 1;
    step();
    idle_inputs();
    chk("rst_err", err, 1'b1);
    chk("rst_rd", rd_count, 32'd1);
    chk("rst_tr", tr_valid, 1'b0);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      s_axi_awid    = 12'($urandom);
      s_axi_awaddr  = $urandom;
      s_axi_awvalid = ($urandom_range(0, 1) == 1);
      s_axi_wdata   = $urandom;
      s_axi_wstrb   = 4'($urandom);
      s_axi_wlast   = 1'($urandom);
      s_axi_wvalid  = 1'($urandom);
      m_axi_awready = ($urandom_range(0, 3) != 0);
      m_axi_wready  = 1'($urandom);
      m_axi_bid     = 12'($urandom);
      m_axi_bvalid  = ($urandom_range(0, 1) == 1);
      s_axi_bready  = ($urandom_range(0, 3) != 0);
      s_axi_arid    = 12'($urandom);
      s_axi_arlen   = 8'($urandom);
      s_axi_araddr  = $urandom;
      s_axi_arvalid = ($urandom_range(0, 1) == 1);
      m_axi_arready = ($urandom_range(0, 3) != 0);
      m_axi_rid     = 12'($urandom);
      m_axi_rdata   = $urandom;
      m_axi_rlast   = ($urandom_range(0, 2) != 0);
      m_axi_rvalid  = ($urandom_range(0, 1) == 1);
      s_axi_rready  = ($urandom_range(0, 3) != 0);
      tw_ready      = ($urandom_range(0, 2) == 0);
      tr_ready      = ($urandom_range(0, 2) == 0);
      enable        = ($urandom_range(0, 9) != 0);
      clear         = ($urandom_range(0, 99) == 0);
      #1;
      if (i % 16 == 0) begin
        chk("pt_awaddr", m_axi_awaddr, s_axi_awaddr);
        chk("pt_awready", s_axi_awready, m_axi_awready);
        chk("pt_wstrb", m_axi_wstrb, s_axi_wstrb);
        chk("pt_bvalid", s_axi_bvalid, m_axi_bvalid);
        chk("pt_arlen", m_axi_arlen, s_axi_arlen);
        chk("pt_rdata", s_axi_rdata, m_axi_rdata);
        chk("pt_rready", m_axi_rready, s_axi_rready);
      end
      step();
    end
    idle_inputs();
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
